freq_mac_accum: RTL and testbench

FREQ_MAC_ACCUM -- requirements
Module: freq_mac_accum

---
 rtl/fft_conv_pkg.sv | 38 +++
 rtl/cmul_fx.sv | 65 ++++++
 rtl/freq_mac_accum.sv | 173 +++++++++++++++++
 tb/tb_freq_mac_accum.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_conv_pkg.sv
// -----------------------------------------------------------------------------
// fft_conv_pkg
// Shared definitions for the frequency-domain convolution datapath:
//   - TILE / NUM_EL     : 4x4 tile geometry (16 complex elements per tile)
//   - CPLX_W, FRAC_BITS : signed fixed-point component width and fraction bits
//   - ACC_BITS          : per-component accumulator width
//   - complex_t         : one packed complex element, re in the low half
//   - fsm_state_e       : accumulator control states
//   - eff_num_ch()      : channel count with 0 mapped to 1
// -----------------------------------------------------------------------------
package fft_conv_pkg;

  localparam int TILE      = 4;
  localparam int NUM_EL    = TILE * TILE;
  localparam int CPLX_W    = 32;
  localparam int FRAC_BITS = 16;
  localparam int ACC_BITS  = 40;
  localparam int CNT_W     = 8;

  // First member lands in the upper bits, so re occupies [31:0] and im [63:32].
  typedef struct packed {
    logic signed [CPLX_W-1:0] im;
    logic signed [CPLX_W-1:0] re;
  } complex_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } fsm_state_e;

  // A channel count of zero would never complete; it is run as a single beat.
  function automatic logic [CNT_W-1:0] eff_num_ch(input logic [CNT_W-1:0] cfg);
    return (cfg == '0) ? CNT_W'(1) : cfg;
  endfunction

endpackage

// File: rtl/cmul_fx.sv
// -----------------------------------------------------------------------------
// cmul_fx
// One registered signed fixed-point complex multiply:
//   re = (a_re*b_re - a_im*b_im) >>> FRAC_W
//   im = (a_re*b_im + a_im*b_re) >>> FRAC_W
// Intermediates are 2*DATA_W+1 bits so the sum/difference cannot overflow.
// The shifted result is kept to OUT_W bits (OUT_W <= 2*DATA_W+1), which is
// the same modulo-2^OUT_W value the downstream accumulator works in.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_en                : capture a new product this cycle
//   i_a_re .. i_b_im    : operand components (signed, DATA_W bits)
//   o_re, o_im          : registered product components (OUT_W bits)
// -----------------------------------------------------------------------------
module cmul_fx #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int OUT_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a_re,
  input  logic [DATA_W-1:0] i_a_im,
  input  logic [DATA_W-1:0] i_b_re,
  input  logic [DATA_W-1:0] i_b_im,
  output logic [OUT_W-1:0]  o_re,
  output logic [OUT_W-1:0]  o_im
);

  localparam int FULL_W = 2 * DATA_W + 1;

  logic signed [FULL_W-1:0] w_a_re;
  logic signed [FULL_W-1:0] w_a_im;
  logic signed [FULL_W-1:0] w_b_re;
  logic signed [FULL_W-1:0] w_b_im;
  logic signed [FULL_W-1:0] w_re_full;
  logic signed [FULL_W-1:0] w_im_full;

  logic [OUT_W-1:0] r_re;
  logic [OUT_W-1:0] r_im;

  // Sign-extend operands to the full width before multiplying.
  assign w_a_re = {{(DATA_W+1){i_a_re[DATA_W-1]}}, i_a_re};
  assign w_a_im = {{(DATA_W+1){i_a_im[DATA_W-1]}}, i_a_im};
  assign w_b_re = {{(DATA_W+1){i_b_re[DATA_W-1]}}, i_b_re};
  assign w_b_im = {{(DATA_W+1){i_b_im[DATA_W-1]}}, i_b_im};

  assign w_re_full = (w_a_re * w_b_re) - (w_a_im * w_b_im);
  assign w_im_full = (w_a_re * w_b_im) + (w_a_im * w_b_re);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_re <= '0;
      r_im <= '0;
    end else if (i_en) begin
      r_re <= OUT_W'(w_re_full >>> FRAC_W);
      r_im <= OUT_W'(w_im_full >>> FRAC_W);
    end
  end

  assign o_re = r_re;
  assign o_im = r_im;

endmodule

// File: rtl/freq_mac_accum.sv
// -----------------------------------------------------------------------------
// freq_mac_accum
// Frequency-domain multiply-accumulate over N channels of 4x4 complex tiles.
// Each accepted beat multiplies img_tile by ker_tile elementwise (stage 1,
// cmul_fx), then adds the products into 16 complex accumulators (stage 2).
// After N beats the saturated accumulators are presented on out_tile.
//
// Handshake: a beat transfers on any cycle with in_valid && in_ready; the
// result transfers on any cycle with out_valid && out_ready. in_ready is high
// only in IDLE/ACCUM; out_valid is high only in OUT, where out_tile is held.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   cfg_num_ch     : channels per tile (0 runs as 1), sampled on first beat
//   in_valid/ready : input tile-pair handshake
//   img_tile       : image tile, element e: re [64e+31:64e], im [64e+63:64e+32]
//   ker_tile       : kernel tile, same packing
//   out_valid/ready: output handshake
//   out_tile       : accumulated tile, saturated to signed DATA_W per component
//   dbg_state      : current FSM state (fsm_state_e encoding)
// -----------------------------------------------------------------------------
module freq_mac_accum
  import fft_conv_pkg::*;
#(
  parameter int DATA_W = CPLX_W,
  parameter int FRAC_W = FRAC_BITS,
  parameter int ACC_W  = ACC_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CNT_W-1:0]           cfg_num_ch,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_EL*2*DATA_W-1:0] img_tile,
  input  logic [NUM_EL*2*DATA_W-1:0] ker_tile,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_EL*2*DATA_W-1:0] out_tile,
  output logic [1:0]                 dbg_state
);

  fsm_state_e       r_state;
  fsm_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] w_cfg_n;
  logic             w_accept;
  logic             w_last_beat;

  // Stage-1 sideband: product valid, first beat of tile, last beat of tile.
  logic r_s1_valid;
  logic r_s1_first;
  logic r_s1_last;

  logic [ACC_W-1:0] w_p_re   [NUM_EL];
  logic [ACC_W-1:0] w_p_im   [NUM_EL];
  logic [ACC_W-1:0] r_acc_re [NUM_EL];
  logic [ACC_W-1:0] r_acc_im [NUM_EL];

  assign w_cfg_n   = eff_num_ch(cfg_num_ch);
  assign w_accept  = in_valid & in_ready;
  assign dbg_state = 2'(r_state);

  // Clamp an accumulator to the signed DATA_W range. The value fits when all
  // bits from the DATA_W sign bit upward agree.
  function automatic logic [DATA_W-1:0] sat_fx(input logic [ACC_W-1:0] v);
    logic [ACC_W-DATA_W:0] top_bits;
    top_bits = v[ACC_W-1:DATA_W-1];
    if ((&top_bits) || (~|top_bits)) return v[DATA_W-1:0];
    else if (v[ACC_W-1])             return {1'b1, {(DATA_W-1){1'b0}}};
    else                             return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_last_beat  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready    = 1'b1;
        w_last_beat = (w_cfg_n == CNT_W'(1));
        if (in_valid) w_state_next = w_last_beat ? ST_DRAIN : ST_ACCUM;
      end
      ST_ACCUM: begin
        in_ready    = 1'b1;
        w_last_beat = ((r_cnt + CNT_W'(1)) == r_n);
        if (in_valid && w_last_beat) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The final product leaves stage 1 into the accumulators on this
        // edge, so the pipeline is empty once we reach OUT.
        if (!r_s1_valid || r_s1_last) w_state_next = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------ beat counter, sideband
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_n        <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_first <= w_accept && (r_state == ST_IDLE);
      r_s1_last  <= w_accept && w_last_beat;
      if (w_accept) begin
        if (r_state == ST_IDLE) begin
          r_cnt <= CNT_W'(1);
          r_n   <= w_cfg_n;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if ((r_state == ST_OUT) && out_ready) begin
        r_cnt <= '0;
      end
    end
  end

  // ------------------------------------------- stage 1: complex multiplies
  for (genvar e = 0; e < NUM_EL; e++) begin : g_el
    cmul_fx #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .OUT_W  (ACC_W)
    ) u_cmul (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_accept),
      .i_a_re (img_tile[2*DATA_W*e +: DATA_W]),
      .i_a_im (img_tile[2*DATA_W*e+DATA_W +: DATA_W]),
      .i_b_re (ker_tile[2*DATA_W*e +: DATA_W]),
      .i_b_im (ker_tile[2*DATA_W*e+DATA_W +: DATA_W]),
      .o_re   (w_p_re[e]),
      .o_im   (w_p_im[e])
    );

    assign out_tile[2*DATA_W*e +: DATA_W]        = sat_fx(r_acc_re[e]);
    assign out_tile[2*DATA_W*e+DATA_W +: DATA_W] = sat_fx(r_acc_im[e]);
  end

  // ------------------------------------------------ stage 2: accumulators
  // The first beat of a tile loads, so stale sums never need a clear cycle.
  // Accumulation wraps modulo 2^ACC_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < NUM_EL; e++) begin
        r_acc_re[e] <= '0;
        r_acc_im[e] <= '0;
      end
    end else if (r_s1_valid) begin
      for (int e = 0; e < NUM_EL; e++) begin
        r_acc_re[e] <= r_s1_first ? w_p_re[e] : (r_acc_re[e] + w_p_re[e]);
        r_acc_im[e] <= r_s1_first ? w_p_im[e] : (r_acc_im[e] + w_p_im[e]);
      end
    end
  end

endmodule

// File: tb/tb_freq_mac_accum.sv
module tb_freq_mac_accum;
  import fft_conv_pkg::*;

  localparam int TW = 1024;

  // ------------------------------------------------ clock / reset / DUT
  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    cfg_num_ch;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] img_tile;
  logic [TW-1:0] ker_tile;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_tile;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  freq_mac_accum dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_num_ch (cfg_num_ch),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .img_tile   (img_tile),
    .ker_tile   (ker_tile),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tile   (out_tile),
    .dbg_state  (dbg_state)
  );

  // ------------------------------------------------ scoreboard / model
  int total = 0;
  int bad   = 0;
  logic [TW-1:0] exp_q[$];
  logic signed [39:0] m_re [16];
  logic signed [39:0] m_im [16];

  function automatic logic signed [39:0] mdl_re(input logic signed [31:0] a, b, c, d);
    logic signed [64:0] t;
    t = (65'(a) * 65'(c) - 65'(b) * 65'(d)) >>> 16;
    return t[39:0];
  endfunction

  function automatic logic signed [39:0] mdl_im(input logic signed [31:0] a, b, c, d);
    logic signed [64:0] t;
    t = (65'(a) * 65'(d) + 65'(b) * 65'(c)) >>> 16;
    return t[39:0];
  endfunction

  function automatic logic [31:0] mdl_sat(input logic signed [39:0] v);
    if (v > 40'sh00_7FFF_FFFF) return 32'h7FFF_FFFF;
    if (v < 40'shFF_8000_0000) return 32'h8000_0000;
    return v[31:0];
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    complex_t c;
    for (int e = 0; e < 16; e++) begin
      c.re = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      c.im = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      t[64*e +: 64] = c;
    end
    return t;
  endfunction

  function automatic logic [TW-1:0] fill_tile(input logic [31:0] re, input logic [31:0] im);
    logic [TW-1:0] t;
    complex_t c;
    c.re = re;
    c.im = im;
    for (int e = 0; e < 16; e++) t[64*e +: 64] = c;
    return t;
  endfunction

  function automatic int first_diff(input logic [TW-1:0] a, input logic [TW-1:0] b);
    for (int e = 0; e < 16; e++)
      if (a[64*e +: 64] !== b[64*e +: 64]) return e;
    return 0;
  endfunction

  // ------------------------------------------------ driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Drives one beat (after `gap` idle cycles) and folds it into the model.
  task automatic send_beat(input logic [TW-1:0] img, input logic [TW-1:0] ker,
                           input int gap, input logic first);
    complex_t a, b;
    repeat (gap) step();
    for (int e = 0; e < 16; e++) begin
      a = img[64*e +: 64];
      b = ker[64*e +: 64];
      if (first) begin
        m_re[e] = mdl_re(a.re, a.im, b.re, b.im);
        m_im[e] = mdl_im(a.re, a.im, b.re, b.im);
      end else begin
        m_re[e] = m_re[e] + mdl_re(a.re, a.im, b.re, b.im);
        m_im[e] = m_im[e] + mdl_im(a.re, a.im, b.re, b.im);
      end
    end
    in_valid = 1'b1;
    img_tile = img;
    ker_tile = ker;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_expected();
    logic [TW-1:0] t;
    for (int e = 0; e < 16; e++) begin
      t[64*e +: 32]    = mdl_sat(m_re[e]);
      t[64*e+32 +: 32] = mdl_sat(m_im[e]);
    end
    exp_q.push_back(t);
  endtask

  // Edges until out_valid is seen, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic transfer();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // ------------------------------------------------ tests
  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_tile !== '0) begin bad++; $display("FAIL reset_out_tile elem=%0d got=%h exp=0", first_diff(out_tile, '0), out_tile[63:0]); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_single();
    logic [TW-1:0] img, ker, exp_t;
    complex_t c;
    int lat;
    img = '0;
    ker = '0;
    c.re = 32'h0001_0000; c.im = '0; img[63:0] = c;
    c.re = 32'h0002_0000; c.im = '0; ker[63:0] = c;
    cfg_num_ch = 8'd1;
    send_beat(img, ker, 0, 1'b1);
    push_expected();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL single_drain_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    wait_out(lat);
    total++; if (lat != 1) begin bad++; $display("FAIL single_latency got=%0d exp=1", lat); end
    exp_t = exp_q.pop_front();
    total++; if (out_tile !== exp_t) begin bad++; $display("FAIL single_tile elem=%0d got=%h exp=%h", first_diff(out_tile, exp_t), out_tile[64*first_diff(out_tile, exp_t) +: 64], exp_t[64*first_diff(out_tile, exp_t) +: 64]); end
    total++; if (out_tile[63:0] !== 64'h0000_0000_0002_0000) begin bad++; $display("FAIL single_elem0 got=%h exp=0000000000020000", out_tile[63:0]); end
    transfer();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL single_after_xfer ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] img, ker, exp_t;
    int lat;
    img = fill_tile(32'h0001_0000, 32'h0001_0000);
    ker = fill_tile(32'h0001_0000, 32'hFFFF_0000);
    cfg_num_ch = 8'd4;
    for (int i = 0; i < 4; i++) send_beat(img, ker, 0, i == 0);
    push_expected();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_drain_ready got=%b exp=0", in_ready); end
    wait_out(lat);
    total++; if (lat != 1) begin bad++; $display("FAIL b2b_latency got=%0d exp=1", lat); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_out_ready got=%b exp=0", in_ready); end
    exp_t = exp_q.pop_front();
    total++; if (out_tile !== exp_t) begin bad++; $display("FAIL b2b_tile elem=%0d got=%h exp=%h", first_diff(out_tile, exp_t), out_tile[64*first_diff(out_tile, exp_t) +: 64], exp_t[64*first_diff(out_tile, exp_t) +: 64]); end
    total++; if (out_tile[64*9 +: 64] !== 64'h0000_0000_0008_0000) begin bad++; $display("FAIL b2b_elem9 got=%h exp=0000000000080000", out_tile[64*9 +: 64]); end
    transfer();
  endtask

  task automatic test_gaps();
    logic [TW-1:0] ti[3], tk[3];
    logic [TW-1:0] exp_t, ref_t;
    int gaps[3];
    int lat;
    gaps[0] = 0; gaps[1] = 2; gaps[2] = 5;
    for (int i = 0; i < 3; i++) begin ti[i] = rand_tile(); tk[i] = rand_tile(); end
    // gap-free reference run
    cfg_num_ch = 8'd3;
    for (int i = 0; i < 3; i++) send_beat(ti[i], tk[i], 0, i == 0);
    push_expected();
    wait_out(lat);
    exp_t = exp_q.pop_front();
    total++; if (out_tile !== exp_t) begin bad++; $display("FAIL nogap_tile elem=%0d got=%h exp=%h", first_diff(out_tile, exp_t), out_tile[64*first_diff(out_tile, exp_t) +: 64], exp_t[64*first_diff(out_tile, exp_t) +: 64]); end
    ref_t = out_tile;
    transfer();
    // gapped run; cfg changes mid-tile must not matter
    for (int i = 0; i < 3; i++) begin
      send_beat(ti[i], tk[i], gaps[i], i == 0);
      cfg_num_ch = 8'd7;
    end
    push_expected();
    wait_out(lat);
    total++; if (lat != 1) begin bad++; $display("FAIL gap_latency got=%0d exp=1", lat); end
    exp_t = exp_q.pop_front();
    total++; if (out_tile !== exp_t) begin bad++; $display("FAIL gap_tile elem=%0d got=%h exp=%h", first_diff(out_tile, exp_t), out_tile[64*first_diff(out_tile, exp_t) +: 64], exp_t[64*first_diff(out_tile, exp_t) +: 64]); end
    total++; if (out_tile !== ref_t) begin bad++; $display("FAIL gap_vs_nogap elem=%0d got=%h exp=%h", first_diff(out_tile, ref_t), out_tile[64*first_diff(out_tile, ref_t) +: 64], ref_t[64*first_diff(out_tile, ref_t) +: 64]); end
    transfer();
  endtask

  task automatic test_saturate();
    logic [TW-1:0] exp_t;
    int lat;
    // +30000.0 * +30000.0, two beats -> positive clamp
    cfg_num_ch = 8'd2;
    for (int i = 0; i < 2; i++)
      send_beat(fill_tile(32'h7530_0000, 32'h0), fill_tile(32'h7530_0000, 32'h0), 0, i == 0);
    push_expected();
    wait_out(lat);
    exp_t = exp_q.pop_front();
    total++; if (out_tile !== exp_t) begin bad++; $display("FAIL sat_pos_tile elem=%0d got=%h exp=%h", first_diff(out_tile, exp_t), out_tile[64*first_diff(out_tile, exp_t) +: 64], exp_t[64*first_diff(out_tile, exp_t) +: 64]); end
    total++; if (out_tile[64*5 +: 32] !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_pos_re got=%h exp=7fffffff", out_tile[64*5 +: 32]); end
    transfer();
    // -30000.0 * +30000.0 -> negative clamp
    for (int i = 0; i < 2; i++)
      send_beat(fill_tile(32'h8AD0_0000, 32'h0), fill_tile(32'h7530_0000, 32'h0), 0, i == 0);
    push_expected();
    wait_out(lat);
    exp_t = exp_q.pop_front();
    total++; if (out_tile !== exp_t) begin bad++; $display("FAIL sat_neg_tile elem=%0d got=%h exp=%h", first_diff(out_tile, exp_t), out_tile[64*first_diff(out_tile, exp_t) +: 64], exp_t[64*first_diff(out_tile, exp_t) +: 64]); end
    total++; if (out_tile[64*12 +: 32] !== 32'h8000_0000) begin bad++; $display("FAIL sat_neg_re got=%h exp=80000000", out_tile[64*12 +: 32]); end
    transfer();
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] exp_t;
    int lat;
    cfg_num_ch = 8'd1;
    send_beat(rand_tile(), rand_tile(), 0, 1'b1);
    push_expected();
    wait_out(lat);
    exp_t = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_%0d valid=%b ready=%b exp valid=1 ready=0", i, out_valid, in_ready); end
      total++; if (out_tile !== exp_t) begin bad++; $display("FAIL bp_stable_%0d elem=%0d got=%h exp=%h", i, first_diff(out_tile, exp_t), out_tile[64*first_diff(out_tile, exp_t) +: 64], exp_t[64*first_diff(out_tile, exp_t) +: 64]); end
      in_valid = 1'b1;          // must be ignored while in OUT
      img_tile = rand_tile();
      ker_tile = rand_tile();
      step();
    end
    in_valid = 1'b0;
    transfer();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_after_xfer ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL bp_idle_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_reset_abort();
    logic [TW-1:0] exp_t;
    int lat;
    cfg_num_ch = 8'd4;
    send_beat(rand_tile(), rand_tile(), 0, 1'b1);
    send_beat(rand_tile(), rand_tile(), 0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL abort_ready ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
    total++; if (out_tile !== '0) begin bad++; $display("FAIL abort_cleared elem=%0d got=%h exp=0", first_diff(out_tile, '0), out_tile[64*first_diff(out_tile, '0) +: 64]); end
    for (int i = 0; i < 4; i++) send_beat(rand_tile(), rand_tile(), 0, i == 0);
    push_expected();
    wait_out(lat);
    total++; if (lat != 1) begin bad++; $display("FAIL abort_latency got=%0d exp=1", lat); end
    exp_t = exp_q.pop_front();
    total++; if (out_tile !== exp_t) begin bad++; $display("FAIL abort_tile elem=%0d got=%h exp=%h", first_diff(out_tile, exp_t), out_tile[64*first_diff(out_tile, exp_t) +: 64], exp_t[64*first_diff(out_tile, exp_t) +: 64]); end
    transfer();
  endtask

  task automatic test_zero_cfg();
    logic [TW-1:0] exp_t;
    int lat;
    cfg_num_ch = 8'd0;
    send_beat(rand_tile(), rand_tile(), 1, 1'b1);
    push_expected();
    wait_out(lat);
    total++; if (lat != 1) begin bad++; $display("FAIL zero_cfg_latency got=%0d exp=1", lat); end
    exp_t = exp_q.pop_front();
    total++; if (out_tile !== exp_t) begin bad++; $display("FAIL zero_cfg_tile elem=%0d got=%h exp=%h", first_diff(out_tile, exp_t), out_tile[64*first_diff(out_tile, exp_t) +: 64], exp_t[64*first_diff(out_tile, exp_t) +: 64]); end
    transfer();
  endtask

  // ------------------------------------------------ sequence and report
  initial begin
    reset      = 1'b1;
    cfg_num_ch = 8'd1;
    in_valid   = 1'b0;
    img_tile   = '0;
    ker_tile   = '0;
    out_ready  = 1'b0;

    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_saturate();
    test_backpressure();
    test_reset_abort();
    test_zero_cfg();

    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
